// File: rtl/pad_ip_mux.sv
// pad_ip_mux: pad-ring selector between the chip pads and the hosted IP cores.
// Synchronises raw pad inputs and strap pins, qualifies a stable strap value,
// holds every IP in reset for a fixed time, then drives the pads from the
// selected IP's output/OE slice until the next reset.
// Optional build macro PAD_MUX_SELCHK_EN: an out-of-range strap parks the block
// in a sticky ERROR state and raises err_o instead of falling back to IP 0.
module pad_ip_mux #(
    parameter int PAD_W       = 82,
    parameter int NUM_IP      = 3,
    parameter int SEL_W       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_CYC  = 16,
    parameter int RST_HOLD    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SEL_W-1:0]         strap_i,
    input  logic [PAD_W-1:0]         io_pad_i,
    output logic [PAD_W-1:0]         io_pad_o,
    output logic [PAD_W-1:0]         io_pad_oe,
    output logic [PAD_W-1:0]         ip_pad_i,
    input  logic [NUM_IP*PAD_W-1:0]  ip_pad_o,
    input  logic [NUM_IP*PAD_W-1:0]  ip_pad_oe,
    output logic [NUM_IP-1:0]        ip_rst_o,
    output logic [SEL_W-1:0]         sel_o,
    output logic                     locked_o
`ifdef PAD_MUX_SELCHK_EN
    ,
    output logic                     err_o
`endif
);

    localparam int CNT_W  = (SAMPLE_CYC > 1) ? $clog2(SAMPLE_CYC) : 1;
    localparam int HCNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(RST_HOLD - 1);

    localparam logic [1:0] ST_SAMPLE  = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
`ifdef PAD_MUX_SELCHK_EN
    localparam logic [1:0] ST_ERROR   = 2'd3;
`endif

    logic [PAD_W-1:0]  pad_sync   [SYNC_STAGES];
    logic [SEL_W-1:0]  strap_sync [SYNC_STAGES];
    logic [SEL_W-1:0]  strap_s;
    logic [SEL_W-1:0]  cand;
    logic [CNT_W-1:0]  cnt;
    logic [HCNT_W-1:0] hcnt;
    logic [1:0]        state;
    logic              cand_ok;
    logic [PAD_W-1:0]  sel_pad_o;
    logic [PAD_W-1:0]  sel_pad_oe;

    // Multi-flop synchronisers for the raw pads and strap pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                pad_sync[i]   <= '0;
                strap_sync[i] <= '0;
            end
        end else begin
            pad_sync[0]   <= io_pad_i;
            strap_sync[0] <= strap_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                pad_sync[i]   <= pad_sync[i-1];
                strap_sync[i] <= strap_sync[i-1];
            end
        end
    end

    assign ip_pad_i = pad_sync[SYNC_STAGES-1];
    assign strap_s  = strap_sync[SYNC_STAGES-1];
    assign cand_ok  = (int'(cand) < NUM_IP);

    // Pick the output/OE slice of the latched IP.
    always_comb begin
        sel_pad_o  = '0;
        sel_pad_oe = '0;
        for (int k = 0; k < NUM_IP; k++) begin
            if (sel_o == SEL_W'(k)) begin
                sel_pad_o  = ip_pad_o[k*PAD_W +: PAD_W];
                sel_pad_oe = ip_pad_oe[k*PAD_W +: PAD_W];
            end
        end
    end

    // Strap qualification, IP reset sequencing and registered pad drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SAMPLE;
            cand      <= '0;
            cnt       <= '0;
            hcnt      <= '0;
            sel_o     <= '0;
            locked_o  <= 1'b0;
            ip_rst_o  <= '1;
            io_pad_o  <= '0;
            io_pad_oe <= '0;
`ifdef PAD_MUX_SELCHK_EN
            err_o     <= 1'b0;
`endif
        end else begin
            // Pads stay tri-stated unless LOCKED overrides below.
            io_pad_o  <= '0;
            io_pad_oe <= '0;
            case (state)
                ST_SAMPLE: begin
                    if (strap_s != cand) begin
                        cand <= strap_s;
                        cnt  <= '0;
                    end else if (cnt == CNT_LAST) begin
                        cnt  <= '0;
                        hcnt <= '0;
`ifdef PAD_MUX_SELCHK_EN
                        if (cand_ok) begin
                            sel_o <= cand;
                            state <= ST_RELEASE;
                        end else begin
                            err_o <= 1'b1;
                            state <= ST_ERROR;
                        end
`else
                        // Out-of-range straps fall back to IP 0.
                        sel_o <= cand_ok ? cand : '0;
                        state <= ST_RELEASE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (hcnt == HCNT_LAST) begin
                        hcnt     <= '0;
                        state    <= ST_LOCKED;
                        locked_o <= 1'b1;
                        ip_rst_o <= ~(NUM_IP'(1) << sel_o);
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    io_pad_o  <= sel_pad_o;
                    io_pad_oe <= sel_pad_oe;
                end
`ifdef PAD_MUX_SELCHK_EN
                ST_ERROR: begin
                    err_o <= 1'b1;
                end
`endif
                default: begin
                    state <= ST_SAMPLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pad_ip_mux.sv
// Directed bench for pad_ip_mux with default parameters.
module tb_pad_ip_mux;

    localparam int PAD_W  = 82;
    localparam int NUM_IP = 3;
    localparam int SEL_W  = 2;

    logic                    clk;
    logic                    rst;
    logic [SEL_W-1:0]        strap_i;
    logic [PAD_W-1:0]        io_pad_i;
    logic [PAD_W-1:0]        io_pad_o;
    logic [PAD_W-1:0]        io_pad_oe;
    logic [PAD_W-1:0]        ip_pad_i;
    logic [NUM_IP*PAD_W-1:0] ip_pad_o;
    logic [NUM_IP*PAD_W-1:0] ip_pad_oe;
    logic [NUM_IP-1:0]       ip_rst_o;
    logic [SEL_W-1:0]        sel_o;
    logic                    locked_o;
`ifdef PAD_MUX_SELCHK_EN
    logic                    err_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [PAD_W-1:0] ones;
    logic [PAD_W-1:0] pat1;
    logic [PAD_W-1:0] pat2;

    pad_ip_mux dut (
        .clk       (clk),
        .rst       (rst),
        .strap_i   (strap_i),
        .io_pad_i  (io_pad_i),
        .io_pad_o  (io_pad_o),
        .io_pad_oe (io_pad_oe),
        .ip_pad_i  (ip_pad_i),
        .ip_pad_o  (ip_pad_o),
        .ip_pad_oe (ip_pad_oe),
        .ip_rst_o  (ip_rst_o),
        .sel_o     (sel_o),
        .locked_o  (locked_o)
`ifdef PAD_MUX_SELCHK_EN
        ,
        .err_o     (err_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ones      = '1;
        pat1      = {2'b10, 16'hA5C3, 64'h0123_4567_89AB_CDEF};
        pat2      = {2'b01, 16'h5A3C, 64'hFEDC_BA98_7654_3210};
        rst       = 1'b1;
        strap_i   = 2'd2;
        io_pad_i  = '0;
        ip_pad_o  = '0;
        ip_pad_oe = '0;

        // Reset state
        step(4);
        chk("rst_io_pad_o",  256'(io_pad_o),  256'(0));
        chk("rst_io_pad_oe", 256'(io_pad_oe), 256'(0));
        chk("rst_ip_pad_i",  256'(ip_pad_i),  256'(0));
        chk("rst_ip_rst_o",  256'(ip_rst_o),  256'(3'b111));
        chk("rst_sel_o",     256'(sel_o),     256'(0));
        chk("rst_locked_o",  256'(locked_o),  256'(0));
`ifdef PAD_MUX_SELCHK_EN
        chk("rst_err_o",     256'(err_o),     256'(0));
`endif

        // Pre-lock: all IPs drive everything, pads must stay tri-stated;
        // io_pad_i[0] rises and reaches ip_pad_i two edges later.
        rst       = 1'b0;
        ip_pad_o  = '1;
        ip_pad_oe = '1;
        io_pad_i  = 82'h1;
        step(1);                                   // edge 1
        chk("sync_lag1", 256'(ip_pad_i[0]), 256'(0));
        chk("prelock_o_e1", 256'(io_pad_o), 256'(0));
        step(1);                                   // edge 2
        chk("sync_lag2", 256'(ip_pad_i[0]), 256'(1));
        step(10);                                  // edge 12
        chk("prelock_o",  256'(io_pad_o),  256'(0));
        chk("prelock_oe", 256'(io_pad_oe), 256'(0));
        chk("prelock_locked", 256'(locked_o), 256'(0));
        step(14);                                  // edge 26
        chk("lock_e26_locked", 256'(locked_o), 256'(0));
        chk("lock_e26_iprst",  256'(ip_rst_o), 256'(3'b111));
        chk("lock_e26_pad_oe", 256'(io_pad_oe), 256'(0));

        // Lock on strap 2 at edge 27
        ip_pad_o  = {82'h1, ones, ones};
        ip_pad_oe = {pat1, ones, ones};
        step(1);                                   // edge 27
        chk("lock_e27_locked", 256'(locked_o), 256'(1));
        chk("lock_e27_sel",    256'(sel_o),    256'(2));
        chk("lock_e27_iprst",  256'(ip_rst_o), 256'(3'b011));
        chk("lock_e27_pad_o",  256'(io_pad_o), 256'(0));
        step(1);                                   // edge 28
        chk("locked_pad_o",  256'(io_pad_o),  256'(82'h1));
        chk("locked_pad_oe", 256'(io_pad_oe), 256'(pat1));

        // Strap change after lock is ignored
        strap_i   = 2'd0;
        ip_pad_oe = {pat2, 82'h0, 82'h0};
        step(5);
        chk("strap_ign_sel",    256'(sel_o),     256'(2));
        chk("strap_ign_locked", 256'(locked_o),  256'(1));
        chk("strap_ign_pad_oe", 256'(io_pad_oe), 256'(pat2));

        // Reset pulse while LOCKED, then relock after 27 edges
        rst = 1'b1;
        step(1);
        chk("rstpulse_locked", 256'(locked_o),  256'(0));
        chk("rstpulse_iprst",  256'(ip_rst_o),  256'(3'b111));
        chk("rstpulse_pad_oe", 256'(io_pad_oe), 256'(0));
        chk("rstpulse_sel",    256'(sel_o),     256'(0));
        rst     = 1'b0;
        strap_i = 2'd2;
        step(26);
        chk("relock_e26", 256'(locked_o), 256'(0));
        step(1);
        chk("relock_e27",     256'(locked_o), 256'(1));
        chk("relock_e27_sel", 256'(sel_o),    256'(2));

        // Toggling strap never qualifies; then hold 1 and lock
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            strap_i = (i % 2 == 1) ? 2'd2 : 2'd1;
            for (int j = 0; j < 10; j++) begin
                step(1);
                chk("toggle_locked", 256'(locked_o), 256'(0));
            end
        end
        strap_i = 2'd1;
        step(26);
        chk("hold1_e26", 256'(locked_o), 256'(0));
        step(1);
        chk("hold1_locked", 256'(locked_o), 256'(1));
        chk("hold1_sel",    256'(sel_o),    256'(1));
        chk("hold1_iprst",  256'(ip_rst_o), 256'(3'b101));

        // Out-of-range strap 3
        rst = 1'b1;
        step(1);
        rst     = 1'b0;
        strap_i = 2'd3;
`ifdef PAD_MUX_SELCHK_EN
        step(18);
        chk("oor_e18_err", 256'(err_o), 256'(0));
        step(1);
        chk("oor_e19_err",    256'(err_o),    256'(1));
        chk("oor_e19_locked", 256'(locked_o), 256'(0));
        step(10);
        chk("oor_err_sticky", 256'(err_o),     256'(1));
        chk("oor_locked",     256'(locked_o),  256'(0));
        chk("oor_iprst",      256'(ip_rst_o),  256'(3'b111));
        chk("oor_pad_oe",     256'(io_pad_oe), 256'(0));
`else
        step(26);
        chk("oor_e26_locked", 256'(locked_o), 256'(0));
        step(1);
        chk("oor_locked", 256'(locked_o), 256'(1));
        chk("oor_sel",    256'(sel_o),    256'(0));
        chk("oor_iprst",  256'(ip_rst_o), 256'(3'b110));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
